// File: rtl/servo_pwm_axil_slave.sv
// Servo PWM generator with an AXI4-Lite register slave: CTRL, PERIOD, PULSE, SCRATCH.
// PERIOD/PULSE are shadowed so software writes only take effect at a period boundary.
module servo_pwm_axil_slave #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 4
) (
   input  logic                            ACLK,
   input  logic                            ARESETN,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
   input  logic [2:0]                      S_AXI_AWPROT,
   input  logic                            S_AXI_AWVALID,
   output logic                            S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
   input  logic                            S_AXI_WVALID,
   output logic                            S_AXI_WREADY,
   output logic [1:0]                      S_AXI_BRESP,
   output logic                            S_AXI_BVALID,
   input  logic                            S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
   input  logic [2:0]                      S_AXI_ARPROT,
   input  logic                            S_AXI_ARVALID,
   output logic                            S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
   output logic [1:0]                      S_AXI_RRESP,
   output logic                            S_AXI_RVALID,
   input  logic                            S_AXI_RREADY,
   output logic                            PWM_OUT
);

   localparam int DW = C_S_AXI_DATA_WIDTH;
   localparam int SW = DW / 8;

   logic [DW-1:0] ctrl_reg;
   logic [DW-1:0] period_reg;
   logic [DW-1:0] pulse_reg;
   logic [DW-1:0] scratch_reg;
   logic [DW-1:0] period_shadow;
   logic [DW-1:0] pulse_shadow;
   logic [DW-1:0] counter;
   logic [DW-1:0] rd_mux;
   logic          enable_d;
   logic          wr_take;
   logic          wr_fire;
   logic          rd_take;
   logic          rd_fire;

   wire unused_inputs = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR};

   function automatic logic [DW-1:0] merge_bytes(input logic [DW-1:0] old_val,
                                                 input logic [DW-1:0] new_val,
                                                 input logic [SW-1:0] strb);
      logic [DW-1:0] res;
      res = old_val;
      for (int b = 0; b < SW; b++) begin
         if (strb[b]) res[b*8 +: 8] = new_val[b*8 +: 8];
      end
      return res;
   endfunction

   // AW and W are only ever accepted together, and never while a response is pending
   assign wr_take = S_AXI_AWVALID && S_AXI_WVALID && !S_AXI_BVALID && !S_AXI_AWREADY;
   assign wr_fire = S_AXI_AWREADY && S_AXI_WREADY && S_AXI_AWVALID && S_AXI_WVALID;
   assign rd_take = S_AXI_ARVALID && !S_AXI_RVALID && !S_AXI_ARREADY;
   assign rd_fire = S_AXI_ARREADY && S_AXI_ARVALID;

   assign S_AXI_BRESP = 2'b00;
   assign S_AXI_RRESP = 2'b00;

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         S_AXI_AWREADY <= 1'b0;
         S_AXI_WREADY  <= 1'b0;
         S_AXI_BVALID  <= 1'b0;
      end else begin
         S_AXI_AWREADY <= wr_take;
         S_AXI_WREADY  <= wr_take;
         if (wr_fire) S_AXI_BVALID <= 1'b1;
         else if (S_AXI_BREADY) S_AXI_BVALID <= 1'b0;
      end
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         ctrl_reg    <= '0;
         period_reg  <= '0;
         pulse_reg   <= '0;
         scratch_reg <= '0;
      end else if (wr_fire) begin
         case (S_AXI_AWADDR[3:2])
            2'd0: ctrl_reg    <= merge_bytes(ctrl_reg,    S_AXI_WDATA, S_AXI_WSTRB);
            2'd1: period_reg  <= merge_bytes(period_reg,  S_AXI_WDATA, S_AXI_WSTRB);
            2'd2: pulse_reg   <= merge_bytes(pulse_reg,   S_AXI_WDATA, S_AXI_WSTRB);
            2'd3: scratch_reg <= merge_bytes(scratch_reg, S_AXI_WDATA, S_AXI_WSTRB);
         endcase
      end
   end

   always_comb begin
      rd_mux = '0;
      case (S_AXI_ARADDR[3:2])
         2'd0: rd_mux = ctrl_reg;
         2'd1: rd_mux = period_reg;
         2'd2: rd_mux = pulse_reg;
         2'd3: rd_mux = scratch_reg;
      endcase
   end

   // Read data is sampled on the AR handshake edge, so a simultaneous write is not yet visible
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         S_AXI_ARREADY <= 1'b0;
         S_AXI_RVALID  <= 1'b0;
         S_AXI_RDATA   <= '0;
      end else begin
         S_AXI_ARREADY <= rd_take;
         if (rd_fire) begin
            S_AXI_RVALID <= 1'b1;
            S_AXI_RDATA  <= rd_mux;
         end else if (S_AXI_RREADY) begin
            S_AXI_RVALID <= 1'b0;
         end
      end
   end

   // Enable edge restarts the period from fresh shadows; a zero period parks the counter
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         enable_d      <= 1'b0;
         counter       <= '0;
         period_shadow <= '0;
         pulse_shadow  <= '0;
         PWM_OUT       <= 1'b0;
      end else if (!ctrl_reg[0]) begin
         enable_d <= 1'b0;
         counter  <= '0;
         PWM_OUT  <= 1'b0;
      end else if (!enable_d) begin
         enable_d      <= 1'b1;
         counter       <= '0;
         period_shadow <= period_reg;
         pulse_shadow  <= pulse_reg;
         PWM_OUT       <= 1'b0;
      end else begin
         PWM_OUT <= (period_shadow != '0) && (counter < pulse_shadow);
         if ((period_shadow == '0) || (counter == period_shadow - 1'b1)) begin
            counter       <= '0;
            period_shadow <= period_reg;
            pulse_shadow  <= pulse_reg;
         end else begin
            counter <= counter + 1'b1;
         end
      end
   end

endmodule

// File: doc/servo_pwm_axil_slave.md
SERVO_PWM_AXIL_SLAVE -- requirements
Module: servo_pwm_axil_slave

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, AXI4-Lite data width (only 32 supported).
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 4, AXI4-Lite byte address width.
REQ-003 SHALL use one clock and an asynchronous, active-low reset, with ports as follows.
REQ-004 SHALL have port ACLK  in  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port ARESETN  in  1  asynchronous active-low reset.
REQ-006 SHALL have port S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address.
REQ-007 SHALL have port S_AXI_AWPROT  in  3  write protection; ignored.
REQ-008 SHALL have port S_AXI_AWVALID  in  1  write address valid.
REQ-009 SHALL have port S_AXI_AWREADY  out  1  write address accepted.
REQ-010 SHALL have port S_AXI_WDATA  in  32  write data.
REQ-011 SHALL have port S_AXI_WSTRB  in  4  write byte enables.
REQ-012 SHALL have port S_AXI_WVALID  in  1  write data valid.
REQ-013 SHALL have port S_AXI_WREADY  out  1  write data accepted.
REQ-014 SHALL have port S_AXI_BRESP  out  2  write response; always 2'b00.
REQ-015 SHALL have port S_AXI_BVALID  out  1  write response valid.
REQ-016 SHALL have port S_AXI_BREADY  in  1  master accepts write response.
REQ-017 SHALL have port S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address.
REQ-018 SHALL have port S_AXI_ARPROT  in  3  read protection; ignored.
REQ-019 SHALL have port S_AXI_ARVALID  in  1  read address valid.
REQ-020 SHALL have port S_AXI_ARREADY  out  1  read address accepted.
REQ-021 SHALL have port S_AXI_RDATA  out  32  read data.
REQ-022 SHALL have port S_AXI_RRESP  out  2  read response; always 2'b00.
REQ-023 SHALL have port S_AXI_RVALID  out  1  read data valid.
REQ-024 SHALL have port S_AXI_RREADY  in  1  master accepts read data.
REQ-025 SHALL have port PWM_OUT  out  1  registered servo PWM output.

Function
REQ-026 SHALL decode ADDR[3:2]: 0=CTRL (bit0 enable), 1=PERIOD (ticks), 2=PULSE (high ticks), 3=SCRATCH; ADDR[1:0] ignored; all four 32-bit R/W, full value read back.
REQ-027 SHALL assert AWREADY and WREADY together for exactly one cycle when AWVALID&&WVALID&&!BVALID&&!AWREADY; no acceptance of only one of AW/W.
REQ-028 SHALL update the addressed register on that handshake edge, per byte lane where WSTRB[n]=1; lanes with WSTRB[n]=0 unchanged.
REQ-029 SHALL assert BVALID the cycle after the write handshake and hold it until BVALID&&BREADY; no new write accepted while BVALID=1.
REQ-030 SHALL assert ARREADY for one cycle when ARVALID&&!RVALID&&!ARREADY; RDATA captured on that edge, RVALID asserted next cycle.
REQ-031 SHALL hold RVALID and RDATA stable until RVALID&&RREADY; no new read accepted while RVALID=1.
REQ-032 SHALL, on same-cycle read and write handshakes to one register, return the pre-write value.
REQ-033 SHALL run a 32-bit counter 0..P-1 while CTRL[0]=1, where P/W are shadow copies of PERIOD/PULSE.
REQ-034 SHALL load shadows when counter==P-1, or on the cycle CTRL[0] goes 0->1 (counter starts at 0 next cycle); mid-period register writes take effect at next period start.
REQ-035 SHALL drive PWM_OUT <= (counter < W), registered, one-cycle latency from counter.
REQ-036 SHALL, with P=0, hold counter at 0, PWM_OUT=0, and reload shadows every cycle; W>=P gives PWM_OUT constantly 1; W=0 gives constantly 0.
REQ-037 SHALL, when CTRL[0]=0, clear counter and drive PWM_OUT=0 on the next edge.

Reset
REQ-038 SHALL, while ARESETN=0, asynchronously clear all registers, shadows, counter, and all outputs (READY/VALID, RDATA, PWM_OUT) to 0.
REQ-039 SHALL drop any in-flight transaction on reset; first handshake possible on the first edge after ARESETN deasserts.

Verification
REQ-040 SHALL cover: write 0x1,0x2,0x3,0x4 to 0x0,0x4,0x8,0xC, read back -> 0x1,0x2,0x3,0x4, BRESP/RRESP=0.
REQ-041 SHALL cover: PERIOD=0x2, then write 0xAABBCCDD WSTRB=4'b0010 to 0x4 -> read 0x0000CC02.
REQ-042 SHALL cover: PERIOD=10, PULSE=3, CTRL=1 -> PWM_OUT repeats 3 cycles high, 7 low; PULSE=5 written mid-period -> 5 high from next period.
REQ-043 SHALL cover: BREADY held low 5 cycles -> BVALID stays 1, AWREADY stays 0 despite new AWVALID/WVALID; same for RREADY/RVALID/ARREADY.
REQ-044 SHALL cover: PULSE=20, PERIOD=10 -> PWM_OUT constant 1; CTRL=0 -> PWM_OUT 0 next cycle.
REQ-045 SHALL cover: ARESETN low during BVALID=1 with CTRL=1 -> BVALID, PWM_OUT, all registers 0 immediately; readback 0 after release.
